modulus_iter: RTL

MODULUS_ITER -- requirements
Module: modulus_iter

---
 rtl/modulus_pkg.sv | 13 +
 rtl/modulus_step.sv | 31 +++
 rtl/modulus_iter.sv | 102 ++++++++++
 3 files changed

// File: rtl/modulus_pkg.sv
// Shared types and constants for the iterative modulus/divide unit.
package modulus_pkg;

  // Default operand and result width.
  localparam int DEFAULT_WIDTH = 16;

  // Controller states: waiting for a request, or iterating.
  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

endpackage

// File: rtl/modulus_step.sv
// One restoring shift-subtract iteration. Shifts the next dividend bit into
// the partial remainder and subtracts the divisor when it fits.
module modulus_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_rem,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Trial subtraction; keep the shifted remainder if the result goes negative.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    next_rem = '0;
    q_bit    = 1'b0;
    shifted  = {part_rem, next_bit};
    diff     = shifted - {2'b00, divisor};
    if (diff[WIDTH+1]) begin
      next_rem = shifted[WIDTH:0];
    end else begin
      next_rem = diff[WIDTH:0];
      q_bit    = 1'b1;
    end
  end

endmodule

// File: rtl/modulus_iter.sv
// Iterative unsigned modulus/divide: one quotient bit per clock, MSB first.
// A zero divisor short-circuits to an error result one cycle after acceptance.
module modulus_iter
  import modulus_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] value_in,
  input  logic [WIDTH-1:0] modulus_in,
  output logic [WIDTH-1:0] value_out,
  output logic [WIDTH-1:0] quotient_out,
  output logic             busy_out,
  output logic             valid_out,
  output logic             error_out
);

  // Step counter runs 0..WIDTH-1 across the WIDTH iterations.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic [WIDTH:0]  rem_q;    // partial remainder, one guard bit wide
  logic [WIDTH-1:0] work_q;  // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] div_q;
  logic            zero_q;   // captured divisor was zero

  logic [WIDTH:0]  rem_next;
  logic            q_bit;

  modulus_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .part_rem (rem_q),
    .next_bit (work_q[WIDTH-1]),
    .divisor  (div_q),
    .next_rem (rem_next),
    .q_bit    (q_bit)
  );

  // Controller and datapath registers, including the registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      // NOTE: every register, data included, is cleared so an abandoned
      // calculation leaves nothing behind.
      state        <= IDLE;
      count        <= '0;
      rem_q        <= '0;
      work_q       <= '0;
      div_q        <= '0;
      zero_q       <= 1'b0;
      value_out    <= '0;
      quotient_out <= '0;
      busy_out     <= 1'b0;
      valid_out    <= 1'b0;
      error_out    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      valid_out <= 1'b0;
      error_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            state    <= CALC;
            busy_out <= 1'b1;
            count    <= '0;
            rem_q    <= '0;
            work_q   <= value_in;
            div_q    <= modulus_in;
            zero_q   <= (modulus_in == '0);
          end
        end
        CALC: begin
          if (zero_q) begin
            value_out    <= work_q;
            quotient_out <= '1;
            error_out    <= 1'b1;
            valid_out    <= 1'b1;
            busy_out     <= 1'b0;
            state        <= IDLE;
          end else begin
            rem_q  <= rem_next;
            work_q <= {work_q[WIDTH-2:0], q_bit};
            count  <= count + 1'b1;
            if (count == LAST_STEP) begin
              value_out    <= rem_next[WIDTH-1:0];
              quotient_out <= {work_q[WIDTH-2:0], q_bit};
              valid_out    <= 1'b1;
              busy_out     <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
